// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types: stage state encoding and IF/ID bubble constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } pipe_state_t;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    // IF/ID payload layout: PC+4 and PC above the instruction word.
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] pc;
        logic [31:0] insn;
    } ifid_t;

    localparam int IFID_W = $bits(ifid_t);

    localparam logic [IFID_W-1:0] IFID_BUBBLE = {64'b0, RV_NOP};

endpackage

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry and flush; 1-cycle latency.
// Backpressure: with SKID=1 up_ready is a flop (skid absorbs the stall); with SKID=0 it is !dn_valid | dn_ready.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(IFID_BUBBLE),
    parameter bit                 SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    pipe_state_t       state;
    pipe_state_t       state_next;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_q;
    logic              up_fire;
    logic              dn_fire;

    assign up_fire = up_valid & up_ready;
    assign dn_fire = dn_valid & dn_ready;

    assign dn_valid = (state != EMPTY);
    assign dn_data  = main_q;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            FULL:      occupancy = 2'd1;
            SKID_FULL: occupancy = 2'd2;
            default:   occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VAL;
        end else begin
            state  <= state_next;
            main_q <= main_next;
        end
    end

    // Flush overrides everything; a dn_fire in the same cycle still counts as consumed downstream.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        if (flush) begin
            state_next = EMPTY;
            main_next  = BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_fire) begin
                        main_next  = up_data;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (up_fire && dn_fire) begin
                        main_next = up_data;
                    end else if (up_fire && SKID) begin
                        state_next = SKID_FULL;
                    end else if (dn_fire) begin
                        main_next  = BUBBLE_VAL;
                        state_next = EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (dn_fire) begin
                        main_next  = skid_q;
                        state_next = FULL;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = BUBBLE_VAL;
                end
            endcase
        end
    end

    generate
        if (SKID) begin : g_skid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= BUBBLE_VAL;
                end else if (flush) begin
                    skid_q <= BUBBLE_VAL;
                end else if (state == FULL && up_fire && !dn_fire) begin
                    skid_q <= up_data;
                end else if (state == SKID_FULL && dn_fire) begin
                    skid_q <= BUBBLE_VAL;
                end
            end

            // Registered ready: the hazard unit's dn_ready never reaches up_ready combinationally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    up_ready <= 1'b1;
                end else begin
                    up_ready <= (state_next != SKID_FULL);
                end
            end
        end else begin : g_flat
            assign skid_q   = BUBBLE_VAL;
            assign up_ready = !dn_valid | dn_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: one SKID=1 and one SKID=0 instance, checked with immediate assertions.
module tb_pipe_stage_buffer;

    localparam logic [95:0] NOP = 96'h13;

    logic        clk;
    logic        rst;

    logic        a_flush, a_up_valid, a_up_ready, a_dn_valid, a_dn_ready;
    logic [95:0] a_up_data, a_dn_data;
    logic [1:0]  a_occ;

    logic        b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
    logic [95:0] b_up_data, b_dn_data;
    logic [1:0]  b_occ;

    int tests;
    int fails;

    pipe_stage_buffer #(.DATA_W(96), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .up_valid(a_up_valid), .up_ready(a_up_ready), .up_data(a_up_data),
        .dn_valid(a_dn_valid), .dn_ready(a_dn_ready), .dn_data(a_dn_data),
        .occupancy(a_occ)
    );

    pipe_stage_buffer #(.DATA_W(96), .SKID(1'b0)) u_flat (
        .clk(clk), .rst(rst), .flush(b_flush),
        .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
        .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_data(b_dn_data),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        a_flush = 0; a_up_valid = 0; a_up_data = '0; a_dn_ready = 0;
        b_flush = 0; b_up_valid = 0; b_up_data = '0; b_dn_ready = 0;
        #2;
        check("rst_dn_valid", 96'(a_dn_valid), 96'd0);
        check("rst_dn_data",  a_dn_data, NOP);
        check("rst_up_ready", 96'(a_up_ready), 96'd1);
        check("rst_occ",      96'(a_occ), 96'd0);
        #6 rst = 1'b0;
        step;
        check("idle_dn_valid", 96'(a_dn_valid), 96'd0);
        check("idle_flat_up_ready", 96'(b_up_ready), 96'd1);

        // streaming, dn_ready high
        a_dn_ready = 1; a_up_valid = 1; a_up_data = 96'h11;
        step;
        check("stream_11", a_dn_data, 96'h11);
        check("stream_occ1", 96'(a_occ), 96'd1);
        a_up_data = 96'h22;
        step;
        check("stream_22", a_dn_data, 96'h22);
        check("stream_occ2", 96'(a_occ), 96'd1);
        a_up_data = 96'h33;
        step;
        check("stream_33", a_dn_data, 96'h33);
        check("stream_up_ready", 96'(a_up_ready), 96'd1);
        a_up_valid = 0;
        step;
        check("drain_valid", 96'(a_dn_valid), 96'd0);
        check("drain_bubble", a_dn_data, NOP);

        // stall absorption
        a_dn_ready = 0; a_up_valid = 1; a_up_data = 96'hA1;
        step;
        check("stall_a1_occ", 96'(a_occ), 96'd1);
        a_up_data = 96'hA2;
        step;
        check("stall_hold_a1", a_dn_data, 96'hA1);
        check("stall_occ2", 96'(a_occ), 96'd2);
        check("stall_up_ready", 96'(a_up_ready), 96'd0);
        a_up_data = 96'hA3;
        step;
        check("stall_still_a1", a_dn_data, 96'hA1);
        check("stall_still_occ2", 96'(a_occ), 96'd2);
        a_dn_ready = 1;
        step;
        check("release_a2", a_dn_data, 96'hA2);
        check("release_occ", 96'(a_occ), 96'd1);
        check("release_up_ready", 96'(a_up_ready), 96'd1);
        step;
        check("release_a3", a_dn_data, 96'hA3);
        a_up_valid = 0;
        step;
        check("release_empty", 96'(a_dn_valid), 96'd0);

        // flush in SKID_FULL with B3 presented
        a_dn_ready = 0; a_up_valid = 1; a_up_data = 96'hB1;
        step;
        a_up_data = 96'hB2;
        step;
        check("pre_flush_occ", 96'(a_occ), 96'd2);
        a_flush = 1; a_up_data = 96'hB3;
        step;
        a_flush = 0; a_up_valid = 0;
        check("flush_valid", 96'(a_dn_valid), 96'd0);
        check("flush_bubble", a_dn_data, NOP);
        check("flush_occ", 96'(a_occ), 96'd0);
        check("flush_up_ready", 96'(a_up_ready), 96'd1);
        a_dn_ready = 1;
        step;
        check("flush_no_b3", 96'(a_dn_valid), 96'd0);
        a_flush = 1;
        step;
        a_flush = 0;
        check("flush_empty_occ", 96'(a_occ), 96'd0);
        check("flush_empty_ready", 96'(a_up_ready), 96'd1);

        // SKID=0: combinational ready and in-place replace
        b_up_valid = 1; b_up_data = 96'hC1; b_dn_ready = 0;
        step;
        check("flat_c1", b_dn_data, 96'hC1);
        check("flat_stall_ready", 96'(b_up_ready), 96'd0);
        b_dn_ready = 1;
        #1;
        check("flat_ready_comb", 96'(b_up_ready), 96'd1);
        b_up_data = 96'hC2;
        step;
        check("flat_replace", b_dn_data, 96'hC2);
        check("flat_occ", 96'(b_occ), 96'd1);
        b_up_valid = 0;
        step;
        check("flat_empty", 96'(b_dn_valid), 96'd0);

        // asynchronous reset between edges while FULL
        a_dn_ready = 0; a_up_valid = 1; a_up_data = 96'hD1;
        step;
        a_up_valid = 0;
        check("pre_arst_full", 96'(a_occ), 96'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 96'(a_dn_valid), 96'd0);
        check("arst_data", a_dn_data, NOP);
        check("arst_occ", 96'(a_occ), 96'd0);
        check("arst_ready", 96'(a_up_ready), 96'd1);
        #1 rst = 1'b0;
        step;
        check("post_arst_empty", 96'(a_dn_valid), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline-stage register with a valid/ready handshake, an optional skid entry, and a synchronous flush. It is the generic successor to the fixed IF/ID latch and sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) of each core. With the skid entry enabled, upstream stall (`up_ready`) is fully registered, which breaks the combinational stall path from the hazard unit. Flushed or empty slots present a configurable bubble value, for example a NOP instruction word.

## Interface
Parameters:
- `DATA_W`, default 96: payload width (instruction + PC + PC+4 for IF/ID).
- `BUBBLE_VAL`, default {64'b0, 32'h00000013}: value driven on `dn_data` whenever the stage is empty; also the reset value.
- `SKID`, default 1: 1 adds a second (skid) entry with registered `up_ready`; 0 gives a single entry with combinational `up_ready`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous kill of all held entries (branch redirect / exception).
- `up_valid`  in  1: upstream has data.
- `up_ready`  out  1: stage accepts data this cycle.
- `up_data`  in  DATA_W: upstream payload.
- `dn_valid`  out  1: stage holds valid data.
- `dn_ready`  in  1: downstream accepts (deasserted = stall).
- `dn_data`  out  DATA_W: payload to next stage.
- `occupancy`  out  2: number of valid entries (0..2; at most 1 when SKID=0).

## Operation
- Transfers: `up_fire = up_valid & up_ready`; `dn_fire = dn_valid & dn_ready`.
- Storage: a main entry drives `dn_data`. When SKID=1 there is also a skid entry.
- State machine (SKID=1): EMPTY, FULL, SKID_FULL.
  - EMPTY: on `up_valid`, main <= `up_data` and go to FULL. Otherwise stay.
  - FULL:
    - `up_fire` & `dn_fire`: main <= `up_data`, stay FULL.
    - `up_fire` & !`dn_fire`: skid <= `up_data`, go to SKID_FULL.
    - !`up_fire` & `dn_fire`: main <= BUBBLE_VAL, go to EMPTY.
    - Otherwise hold.
  - SKID_FULL: `up_ready`=0. On `dn_fire`, main <= skid, skid <= BUBBLE_VAL, go to FULL. Otherwise hold.
- `up_ready` (SKID=1) is a flop: it is 1 in the cycle after entering EMPTY or FULL and 0 in SKID_FULL. It never depends combinationally on `dn_ready`.
- SKID=0: only EMPTY and FULL exist. `up_ready = !dn_valid | dn_ready` (combinational). In FULL, simultaneous fire replaces the main entry.
- `dn_valid` = (state != EMPTY); `dn_data` = main entry; `occupancy` = 0/1/2 for EMPTY/FULL/SKID_FULL.
- Flush has highest priority. In the flush cycle:
  - next state is EMPTY;
  - main and skid are loaded with BUBBLE_VAL;
  - any `up_data` presented that cycle is dropped, even if `up_fire`;
  - a `dn_fire` in the flush cycle still completes: downstream consumes the current entry.
- Data is never duplicated and never dropped except by flush. Order is strictly FIFO.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `dn_data` with `dn_valid` after edge N.
- Throughput is 1 transfer per cycle with `dn_ready` held high, in both SKID modes.
- Stall response (SKID=1): `dn_ready` falling at edge N is absorbed by the skid entry. `up_ready` is low after edge N+1 and rises one cycle after the first `dn_fire`.
- Reset (async, effective immediately):
  - state EMPTY;
  - `dn_valid`=0, `dn_data`=BUBBLE_VAL, `occupancy`=0;
  - `up_ready`=1;
  - skid = BUBBLE_VAL.
- Reset mid-transfer discards all entries. The first acceptance occurs at the first rising edge after `rst` deasserts.
- `flush` and `rst` together behave as reset.
- `flush` in EMPTY has no effect.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_t` (EMPTY, FULL, SKID_FULL);
  - constant `RV_NOP = 32'h00000013`;
  - helper constant for the IF/ID bubble vector.
- No sub-module: the skid entry is a small register generated under `if (SKID)`.
- One instance per pipeline boundary. The hazard unit drives `dn_ready` and `flush`.

## Test plan
- Reset then idle: `dn_valid`=0, `dn_data`=96'h…00000013, `up_ready`=1, `occupancy`=0.
- Streaming, SKID=1, `dn_ready`=1: words 0x11, 0x22, 0x33 on consecutive cycles -> emerge 1 cycle later, back-to-back, `occupancy` stays 1.
- Stall absorption, SKID=1: `dn_ready`=0 while 0xA1, 0xA2 are sent.
  - `dn_data` holds 0xA1 and `occupancy`=2.
  - `up_ready` falls; 0xA3 is held upstream.
  - After `dn_ready`=1: 0xA1, 0xA2, 0xA3 appear in order, with no loss or duplication.
- Flush in SKID_FULL with `up_valid`=1 (data 0xB3): next cycle `dn_valid`=0, `dn_data`=NOP bubble, `occupancy`=0; 0xB3 is not delivered.
- SKID=0 instance: `dn_ready`=0 with FULL -> `up_ready`=0 in the same cycle; `dn_ready` and `up_valid` both 1 -> replace in one cycle.
- Async reset asserted between clock edges while in FULL: outputs go to reset values immediately, without a clock edge.
